// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity-type codes and legal
// parameter bounds used by the TX framer and the future RX checker.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_WAIT   = ST_WAIT,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 9;
  localparam int STOP_BITS_MIN  = 1;
  localparam int STOP_BITS_MAX  = 2;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational UART parity generator: even parity makes the total count of
// ones (data plus parity) even, odd parity makes it odd.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity_bit
);

  assign parity_bit = (par_typ == PAR_ODD) ? ~^data : ^data;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: latches a word and serialises start, data (LSB first),
// optional parity and stop bits, advancing one bit per baud tick.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_width
    $error("uart_tx_frame: DATA_WIDTH out of range");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS out of range");
  end

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                    stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    par_en_q;
  logic                    parity_q;
  logic                    parity_bit;
  logic                    capture;
  logic                    tx_q, tx_d;

  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data      (p_data),
    .par_typ   (par_typ),
    .parity_bit(parity_bit)
  );

  // The line level is decoded from the next state so it changes on the same
  // edge as the transition that starts the bit.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    capture    = 1'b0;
    tx_d       = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (data_valid) begin
          capture = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tick) state_d = S_START;
      end
      S_START: begin
        if (tick) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d    = par_en_q ? S_PARITY : S_STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d    = S_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (stop_cnt_q != LAST_STOP) stop_cnt_d = stop_cnt_q + 1'b1;
          else                         state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_q[bit_cnt_d];
      S_PARITY: tx_d = parity_q;
      default:  tx_d = 1'b1;
    endcase
  end

  // Frame configuration is captured only on acceptance, so input churn while
  // busy cannot disturb the frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      if (capture) begin
        data_q   <= p_data;
        par_en_q <= par_en;
        parity_q <= parity_bit;
      end
    end
  end

  assign tx_out = tx_q;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: three configurations (8N1, 8 data/2 stop,
// 5 data/1 stop) share one stimulus/monitor pair through a selector.
module tb_uart_tx_frame;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          exp_lat;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [7:0] p_data;
  logic       par_en;
  logic       par_typ;
  logic       dv;
  logic [1:0] sel;
  logic       mon_en;

  logic [2:0] dv_arr;
  logic [2:0] tx_arr;
  logic [2:0] busy_arr;
  logic       tx_s;
  logic       busy_s;

  int     vectors    = 0;
  int     miscompares = 0;
  int     phase;
  frame_t exp_q[$];

  always #5 clk = ~clk;

  always_comb begin
    dv_arr      = '0;
    dv_arr[sel] = dv;
    tx_s        = tx_arr[sel];
    busy_s      = busy_arr[sel];
  end

  uart_tx_frame #(.DATA_WIDTH(8), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .p_data(p_data), .data_valid(dv_arr[0]),
    .par_en(par_en), .par_typ(par_typ), .tx_out(tx_arr[0]), .busy(busy_arr[0])
  );

  uart_tx_frame #(.DATA_WIDTH(8), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .p_data(p_data), .data_valid(dv_arr[1]),
    .par_en(par_en), .par_typ(par_typ), .tx_out(tx_arr[1]), .busy(busy_arr[1])
  );

  uart_tx_frame #(.DATA_WIDTH(5), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .p_data(p_data[4:0]), .data_valid(dv_arr[2]),
    .par_en(par_en), .par_typ(par_typ), .tx_out(tx_arr[2]), .busy(busy_arr[2])
  );

  // Baud tick: one clock wide, every 16 clocks.
  initial begin
    tick  = 1'b0;
    phase = 0;
    forever begin
      @(negedge clk);
      phase = (phase == 15) ? 0 : phase + 1;
      tick  = (phase == 15);
    end
  end

  task automatic check_output(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference frame: the bit list a UART line carries, built in sending order.
  function automatic frame_t model(input logic [1:0] s, input logic [7:0] d,
                                   input logic pen, input logic ptyp, input int lat);
    frame_t f;
    int dw, sb, k, ones;
    dw = (s == 2'd2) ? 5 : 8;
    sb = (s == 2'd1) ? 2 : 1;
    f.bits = '0;
    k = 0;
    ones = 0;
    f.bits[k] = 1'b0;
    k++;
    for (int i = 0; i < dw; i++) begin
      f.bits[k] = d[i];
      ones += int'(d[i]);
      k++;
    end
    if (pen) begin
      f.bits[k] = ptyp ? ((ones % 2) == 0) : ((ones % 2) == 1);
      k++;
    end
    for (int i = 0; i < sb; i++) begin
      f.bits[k] = 1'b1;
      k++;
    end
    f.nbits   = k;
    f.exp_lat = lat;
    return f;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_s && n < 600) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 600) check_output("wait for idle timeout", 0, 1);
  endtask

  task automatic apply_stimulus(input logic [1:0] s, input logic [7:0] d, input logic pen,
                                input logic ptyp, input logic coincide);
    int n;
    wait_idle();
    sel = s;
    if (coincide) begin
      n = 0;
      while (!tick && n < 40) begin
        @(negedge clk); #1;
        n++;
      end
    end
    p_data  = d;
    par_en  = pen;
    par_typ = ptyp;
    dv      = 1'b1;
    exp_q.push_back(model(s, d, pen, ptyp, coincide ? 16 : 0));
    @(negedge clk); #1;
    dv = 1'b0;
  endtask

  // Monitor: each time the selected DUT goes busy, pop the expected frame and
  // reconstruct the line by sampling every clock until busy drops.
  initial begin
    frame_t      e;
    logic [15:0] got;
    int          lat, n;
    logic        stable;
    forever begin
      @(negedge clk);
      if (!mon_en || !busy_s) continue;
      if (exp_q.size() == 0) begin
        check_output("unexpected frame", 1, 0);
        n = 0;
        while (busy_s && n < 400) begin
          @(negedge clk);
          n++;
        end
        continue;
      end
      e = exp_q.pop_front();
      lat = 0;
      while (tx_s && busy_s && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      if (e.exp_lat == 0) check_output("start latency in 1..16", int'(lat >= 1 && lat <= 16), 1);
      else                check_output("start latency", lat, e.exp_lat);
      got    = '0;
      n      = 0;
      stable = 1'b1;
      while (busy_s && n < 256) begin
        if (n % 16 == 0)             got[n/16] = tx_s;
        else if (tx_s != got[n/16])  stable    = 1'b0;
        n++;
        @(negedge clk);
      end
      check_output("frame length clocks", n, 16 * e.nbits);
      check_output("frame bits", int'(got), int'(e.bits));
      check_output("bit hold 16 clocks", int'(stable), 1);
      check_output("line high at busy fall", int'(tx_s), 1);
    end
  end

  initial begin
    int n, errs;
    rst     = 1'b1;
    mon_en  = 1'b0;
    dv      = 1'b0;
    sel     = 2'd0;
    p_data  = '0;
    par_en  = 1'b0;
    par_typ = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_output("reset tx_out", int'(tx_arr[i]), 1);
      check_output("reset busy", int'(busy_arr[i]), 0);
    end
    rst = 1'b0;
    @(negedge clk); #1;

    // Mid-frame reset on 8N1, 8'hA5, asserted during data bit 3.
    p_data = 8'hA5;
    dv     = 1'b1;
    @(negedge clk); #1;
    dv = 1'b0;
    check_output("busy after accept", int'(busy_s), 1);
    n = 0;
    while (tx_s && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    check_output("start bit seen", int'(tx_s), 0);
    repeat (68) @(negedge clk);
    check_output("data bit 3 level", int'(tx_s), 0);
    #2 rst = 1'b1;
    #1;
    check_output("async reset tx_out", int'(tx_s), 1);
    check_output("async reset busy", int'(busy_s), 0);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    errs = 0;
    repeat (48) begin
      @(negedge clk);
      if (!tx_s || busy_s) errs++;
    end
    check_output("idle after reset", errs, 0);
    mon_en = 1'b1;

    apply_stimulus(2'd0, 8'hA5, 1'b0, 1'b0, 1'b0);
    apply_stimulus(2'd0, 8'h07, 1'b1, 1'b0, 1'b0);
    apply_stimulus(2'd1, 8'h07, 1'b1, 1'b1, 1'b0);

    // Back-to-back with input churn during the first frame.
    wait_idle();
    sel     = 2'd0;
    p_data  = 8'h55;
    par_en  = 1'b0;
    par_typ = 1'b0;
    dv      = 1'b1;
    exp_q.push_back(model(2'd0, 8'h55, 1'b0, 1'b0, 0));
    n = 0;
    while (!busy_s && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    repeat (80) begin
      @(negedge clk); #1;
      p_data  = 8'($urandom);
      par_en  = 1'($urandom);
      par_typ = 1'($urandom);
    end
    p_data  = 8'h3C;
    par_en  = 1'b0;
    par_typ = 1'b0;
    exp_q.push_back(model(2'd0, 8'h3C, 1'b0, 1'b0, 15));
    wait_idle();
    n = 0;
    while (!busy_s && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    dv = 1'b0;

    apply_stimulus(2'd2, 8'($urandom), 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 20; i++) begin
      apply_stimulus(2'($urandom_range(0, 2)), 8'($urandom), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    wait_idle();
    repeat (4) @(negedge clk);
    check_output("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
